// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one MemoryInterface command port between the fetch (f)
// and load/store (d) requesters, with a per-transaction hung-interface timeout.
module memory_arbiter #(
   parameter logic [3:0] CMD_NOP        = 4'd0,
   parameter int         TIMEOUT_CYCLES = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        fReq,
   input  logic [3:0]  fCommand,
   input  logic [31:0] fAddress,
   input  logic [31:0] fWData,
   output logic        fDone,
   output logic [31:0] fData,
   output logic        fFault,
   input  logic        dReq,
   input  logic [3:0]  dCommand,
   input  logic [31:0] dAddress,
   input  logic [31:0] dWData,
   output logic        dDone,
   output logic [31:0] dData,
   output logic        dFault,
   output logic [3:0]  cCommand,
   output logic [31:0] cAddress,
   output logic [31:0] cData,
   input  logic        hReady,
   input  logic        hSignal,
   input  logic [31:0] hData,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DONE  = 2'd2
   } state_t;

   // Counter only has to reach TIMEOUT_CYCLES-1; it saturates at all-ones otherwise.
   localparam int CW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CW-1:0] TIMEOUT_LAST = CW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

   state_t        state_reg, state_next;
   logic          grant_reg, grant_next;          // 0 = f, 1 = d
   logic          last_grant_reg, last_grant_next;
   logic [3:0]    ccmd_reg, ccmd_next;
   logic [31:0]   caddr_reg, caddr_next;
   logic [31:0]   cdata_reg, cdata_next;
   logic [CW-1:0] count_reg, count_next;

   logic          sel;
   logic          result_we;
   logic [31:0]   result_data;
   logic          result_fault;

   logic [1:0]    done_vec;
   logic [1:0]    fault_vec;
   logic [63:0]   data_vec;

   always_comb begin
      state_next      = state_reg;
      grant_next      = grant_reg;
      last_grant_next = last_grant_reg;
      ccmd_next       = ccmd_reg;
      caddr_next      = caddr_reg;
      cdata_next      = cdata_reg;
      count_next      = count_reg;
      sel             = 1'b0;
      result_we       = 1'b0;
      result_data     = '0;
      result_fault    = 1'b0;

      case (state_reg)
         IDLE: begin
            if (fReq || dReq) begin
               // On a tie the requester that did not win last time is served.
               sel             = (fReq && dReq) ? ~last_grant_reg : dReq;
               grant_next      = sel;
               last_grant_next = sel;
               ccmd_next       = sel ? dCommand : fCommand;
               caddr_next      = sel ? dAddress : fAddress;
               cdata_next      = sel ? dWData   : fWData;
               count_next      = '0;
               if (ccmd_next == CMD_NOP) begin
                  state_next = DONE;
                  result_we  = 1'b1;
               end else begin
                  state_next = ISSUE;
               end
            end
         end
         ISSUE: begin
            if (hReady) begin
               result_we    = 1'b1;
               result_data  = hData;
               result_fault = hSignal;
               state_next   = DONE;
               ccmd_next    = CMD_NOP;
            end else if ((TIMEOUT_CYCLES != 0) && (count_reg == TIMEOUT_LAST)) begin
               result_we    = 1'b1;
               result_fault = 1'b1;
               state_next   = DONE;
               ccmd_next    = CMD_NOP;
            end else if (count_reg != {CW{1'b1}}) begin
               count_next = count_reg + CW'(1);
            end
         end
         DONE: begin
            state_next = IDLE;
         end
         default: begin
            state_next = IDLE;
            ccmd_next  = CMD_NOP;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg      <= IDLE;
         grant_reg      <= 1'b0;
         last_grant_reg <= 1'b0;
         ccmd_reg       <= CMD_NOP;
         caddr_reg      <= '0;
         cdata_reg      <= '0;
         count_reg      <= '0;
      end else begin
         state_reg      <= state_next;
         grant_reg      <= grant_next;
         last_grant_reg <= last_grant_next;
         ccmd_reg       <= ccmd_next;
         caddr_reg      <= caddr_next;
         cdata_reg      <= cdata_next;
         count_reg      <= count_next;
      end
   end

   // Per-requester result registers; each holds until its own next completion.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_result
         localparam logic IDX = (gi == 1);
         logic [31:0] data_reg;
         logic        fault_reg;

         always_ff @(posedge clock) begin
            if (!reset) begin
               data_reg  <= '0;
               fault_reg <= 1'b0;
            end else if (result_we && (grant_next == IDX)) begin
               data_reg  <= result_data;
               fault_reg <= result_fault;
            end
         end

         assign done_vec[gi]            = (state_reg == DONE) && (grant_reg == IDX);
         assign fault_vec[gi]           = fault_reg;
         assign data_vec[gi*32 +: 32]   = data_reg;
      end
   endgenerate

   assign fDone    = done_vec[0];
   assign dDone    = done_vec[1];
   assign fFault   = fault_vec[0];
   assign dFault   = fault_vec[1];
   assign fData    = data_vec[31:0];
   assign dData    = data_vec[63:32];
   assign cCommand = ccmd_reg;
   assign cAddress = caddr_reg;
   assign cData    = cdata_reg;
   assign busy     = (state_reg != IDLE);

endmodule
